// File: rtl/sub_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the serial subtractor slice.
//   state_e        : controller state encoding (IDLE=0, SHIFT=1, DONE=2)
//   DEFAULT_WIDTH  : default operand/result width in bits
// ---------------------------------------------------------------------------
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fullsub_HS_46.sv
// ---------------------------------------------------------------------------
// fullsub_HS_46
// One-bit full subtractor cell: computes a - b - cin.
//   a, b  : operand bits
//   cin   : borrow in
//   diff  : difference bit
//   borr  : borrow out
// ---------------------------------------------------------------------------
module fullsub_HS_46 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic diff,
  output logic borr
);

  // A borrow is needed whenever the subtracted amount (b plus cin) exceeds a.
  assign diff = a ^ b ^ cin;
  assign borr = (~a & b) | (~a & cin) | (b & cin);

endmodule

// File: rtl/serial_sub_46.sv
// ---------------------------------------------------------------------------
// serial_sub_46
// Bit-serial subtractor: computes a_in - b_in - bin modulo 2^WIDTH, one bit
// per clock, LSB first, using a single full-subtractor cell.
//   clk      : clock, all state on rising edge
//   rst_n    : asynchronous active-low reset
//   start    : begin a subtraction (accepted only while idle)
//   a_in     : minuend, captured on accepted start
//   b_in     : subtrahend, captured on accepted start
//   bin      : borrow-in, captured on accepted start
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when diff_out/borr_out are updated
//   diff_out : difference, held until the next operation completes
//   borr_out : final borrow out of the MSB stage
// ---------------------------------------------------------------------------
module serial_sub_46
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borr_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] aShift_q;
  logic [WIDTH-1:0] bShift_q;
  logic             borrow_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-2:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] diff_q;
  logic             borrOut_q;
  logic             busy_q;
  logic             done_q;
  logic             diffBit;
  logic             borrBit;

  fullsub_HS_46 uCell (
    .a    (aShift_q[0]),
    .b    (bShift_q[0]),
    .cin  (borrow_q),
    .diff (diffBit),
    .borr (borrBit)
  );

  // The partial result only keeps WIDTH-1 bits; the bit produced in the
  // final shift cycle completes the word directly into the output register,
  // so partial values never reach diff_out.
  assign result_d = {diffBit, result_q};

  // Controller and datapath: operands shift right one bit per SHIFT cycle,
  // the borrow ripples through borrow_q, and the outputs are only loaded on
  // the transition into DONE so they stay stable between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aShift_q  <= '0;
      bShift_q  <= '0;
      borrow_q  <= 1'b0;
      count_q   <= '0;
      result_q  <= '0;
      diff_q    <= '0;
      borrOut_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            aShift_q <= a_in;
            bShift_q <= b_in;
            borrow_q <= bin;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          aShift_q <= aShift_q >> 1;
          bShift_q <= bShift_q >> 1;
          borrow_q <= borrBit;
          result_q <= result_d[WIDTH-1:1];
          count_q  <= count_q + CW'(1);
          if (count_q == LAST_BIT) begin
            diff_q    <= result_d;
            borrOut_q <= borrBit;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff_out = diff_q;
  assign borr_out = borrOut_q;

endmodule

// File: tb/tb_serial_sub_46.sv
// ---------------------------------------------------------------------------
// tb_serial_sub_46
// Directed and random checks of the 8-bit serial subtractor.
// ---------------------------------------------------------------------------
module tb_serial_sub_46;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff_out;
  logic       borr_out;

  int checks;
  int failures;

  serial_sub_46 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff_out (diff_out),
    .borr_out (borr_out)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Launch one operation and wait (bounded) for done. Operands are scrambled
  // right after the start edge so any late re-sampling would corrupt results.
  // Returns with the bench sitting on the negedge where done was seen.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bi,
                               output int cycles, output bit gotDone,
                               output logic busyAfterStart, output logic [7:0] diffDuringBusy);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    bin   = bi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    bin   = ~bi;
    busyAfterStart = busy;
    diffDuringBusy = diff_out;
    cycles  = 1;
    gotDone = 1'b0;
    while (cycles < 40 && !gotDone) begin
      if (done === 1'b1) gotDone = 1'b1;
      else begin
        @(negedge clk);
        cycles++;
      end
    end
  endtask

  // Outputs must be cleared while reset is held and stay idle after release.
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    bin   = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (diff_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_diff: got %h expected 00", diff_out); end
    checks++; if (borr_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_borr: got %b expected 0", borr_out); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  // 5 - 3: latency, busy, result and the single-cycle done pulse.
  task automatic test_basic();
    int cycles; bit gotDone; logic busyStart; logic [7:0] diffMid;
    applyStimulus(8'd5, 8'd3, 1'b0, cycles, gotDone, busyStart, diffMid);
    checks++; if (!gotDone) begin failures++; $display("[TB] FAIL basic_timeout: got no done expected done"); end
    checks++; if (cycles != 9) begin failures++; $display("[TB] FAIL basic_latency: got %0d expected 9", cycles); end
    checks++; if (busyStart !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy: got %b expected 1", busyStart); end
    checks++; if (diff_out !== 8'h02) begin failures++; $display("[TB] FAIL basic_diff: got %h expected 02", diff_out); end
    checks++; if (borr_out !== 1'b0) begin failures++; $display("[TB] FAIL basic_borr: got %b expected 0", borr_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_at_done: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
  endtask

  // Borrow-in only and equal maximal operands.
  task automatic test_boundaries();
    int cycles; bit gotDone; logic busyStart; logic [7:0] diffMid;
    applyStimulus(8'h00, 8'h00, 1'b1, cycles, gotDone, busyStart, diffMid);
    checks++; if (!gotDone || diff_out !== 8'hFF || borr_out !== 1'b1) begin
      failures++; $display("[TB] FAIL bound_zero_bin: got done=%b diff=%h borr=%b expected 1 ff 1", gotDone, diff_out, borr_out);
    end
    applyStimulus(8'hFF, 8'hFF, 1'b0, cycles, gotDone, busyStart, diffMid);
    checks++; if (!gotDone || diff_out !== 8'h00 || borr_out !== 1'b0) begin
      failures++; $display("[TB] FAIL bound_ff_ff: got done=%b diff=%h borr=%b expected 1 00 0", gotDone, diff_out, borr_out);
    end
  endtask

  // 3 - 5 wraps; previous result must be held while the new one is built.
  task automatic test_negative();
    int cycles; bit gotDone; logic busyStart; logic [7:0] diffMid;
    applyStimulus(8'd3, 8'd5, 1'b0, cycles, gotDone, busyStart, diffMid);
    checks++; if (diffMid !== 8'h00) begin failures++; $display("[TB] FAIL neg_hold_prev: got %h expected 00", diffMid); end
    checks++; if (!gotDone || diff_out !== 8'hFE) begin failures++; $display("[TB] FAIL neg_diff: got %h expected fe", diff_out); end
    checks++; if (borr_out !== 1'b1) begin failures++; $display("[TB] FAIL neg_borr: got %b expected 1", borr_out); end
  endtask

  // Start held for 20 edges: ops accepted every 10 cycles, operand noise
  // while busy must not matter.
  task automatic test_back_to_back();
    bit expDone;
    @(negedge clk);
    a_in  = 8'd9;
    b_in  = 8'd4;
    bin   = 1'b0;
    start = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (i == 20) start = 1'b0;
      expDone = (i == 9) || (i == 19);
      checks++; if (done !== expDone) begin failures++; $display("[TB] FAIL b2b_done_%0d: got %b expected %b", i, done, expDone); end
      if (done === 1'b1) begin
        checks++; if (diff_out !== 8'h05 || borr_out !== 1'b0) begin
          failures++; $display("[TB] FAIL b2b_result_%0d: got %h/%b expected 05/0", i, diff_out, borr_out);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_busy_done_%0d: got %b expected 0", i, busy); end
      end
      if ((i % 10) >= 1 && (i % 10) <= 8) begin
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        bin  = 1'($urandom);
      end else begin
        a_in = 8'd9;
        b_in = 8'd4;
        bin  = 1'b0;
      end
    end
  endtask

  // Reset mid-operation aborts without a done pulse; next op is normal.
  task automatic test_reset_abort();
    int cycles; bit gotDone; logic busyStart; logic [7:0] diffMid; int doneSeen;
    @(negedge clk);
    a_in  = 8'd9;
    b_in  = 8'd1;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (diff_out !== 8'h00 || borr_out !== 1'b0) begin
      failures++; $display("[TB] FAIL abort_outputs: got %h/%b expected 00/0", diff_out, borr_out);
    end
    doneSeen = 0;
    repeat (2) begin @(negedge clk); if (done === 1'b1) doneSeen++; end
    rst_n = 1'b1;
    repeat (15) begin @(negedge clk); if (done === 1'b1) doneSeen++; end
    checks++; if (doneSeen != 0) begin failures++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", doneSeen); end
    applyStimulus(8'd7, 8'd2, 1'b0, cycles, gotDone, busyStart, diffMid);
    checks++; if (!gotDone || diff_out !== 8'h05 || borr_out !== 1'b0) begin
      failures++; $display("[TB] FAIL abort_fresh: got done=%b diff=%h borr=%b expected 1 05 0", gotDone, diff_out, borr_out);
    end
  endtask

  // Random operands against a 9-bit arithmetic model.
  task automatic test_random();
    int cycles; bit gotDone; logic busyStart; logic [7:0] diffMid;
    logic [7:0] ra; logic [7:0] rb; logic rbi; logic [8:0] expected;
    for (int n = 0; n < 1000; n++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rbi = 1'($urandom);
      expected = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
      applyStimulus(ra, rb, rbi, cycles, gotDone, busyStart, diffMid);
      checks++;
      if (!gotDone || {borr_out, diff_out} !== expected) begin
        failures++;
        $display("[TB] FAIL random_%0d (%h-%h-%b): got %b/%h expected %b/%h", n, ra, rb, rbi, borr_out, diff_out, expected[8], expected[7:0]);
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_negative();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
